// File: rtl/lv_pwm_intb_decode_pkg.sv
// rtl/lv_pwm_intb_decode_pkg.sv - shared constants, FSM states and window helpers for the PWM INTB link
package lv_pwm_intb_decode_pkg;

   localparam int PWM_INTB_EXT_CYC_NUM = 8;
   localparam int PWM_INTB_EXT_TOL     = 2;

   localparam int WDG_CNT_W = 8;
   // Element [cfg] is the watchdog resend period selected by i_wdgintb_config.
   localparam logic [3:0][WDG_CNT_W-1:0] WDG_INTB_TH = {8'd255, 8'd128, 8'd64, 8'd32};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN1 = 3'd1,
      ST_RUN2 = 3'd2,
      ST_RUN3 = 3'd3,
      ST_RUN4 = 3'd4
   } intb_state_e;

   function automatic int long_th(input int ext_cyc_num, input int ext_tol);
      return ext_cyc_num + ext_tol + 1;
   endfunction

   function automatic int short_min(input int ext_cyc_num, input int ext_tol);
      return ext_cyc_num - ext_tol;
   endfunction

   function automatic int short_max(input int ext_cyc_num, input int ext_tol);
      return ext_cyc_num + ext_tol;
   endfunction

endpackage

// File: rtl/lv_pwm_intb_decode_sync_run_meter.sv
// rtl/lv_pwm_intb_decode_sync_run_meter.sv - line synchronizer, edge detect and run-length classifier
module lv_pwm_intb_decode_sync_run_meter
   import lv_pwm_intb_decode_pkg::*;
#(
   parameter int EXT_CYC_NUM = PWM_INTB_EXT_CYC_NUM,
   parameter int EXT_TOL     = PWM_INTB_EXT_TOL
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_line,
   output logic o_sync,
   output logic o_edge,
   output logic o_short,
   output logic o_glitch,
   output logic o_over,
   output logic o_long
);

   localparam int LONG_TH = long_th(EXT_CYC_NUM, EXT_TOL);
   localparam int CNT_W   = $clog2(LONG_TH + 1);

   localparam logic [CNT_W-1:0] LONG_C    = CNT_W'(LONG_TH);
   localparam logic [CNT_W-1:0] LONG_M1_C = CNT_W'(LONG_TH - 1);
   localparam logic [CNT_W:0]   SMIN_C    = (CNT_W+1)'(short_min(EXT_CYC_NUM, EXT_TOL));
   localparam logic [CNT_W:0]   SMAX_C    = (CNT_W+1)'(short_max(EXT_CYC_NUM, EXT_TOL));
   localparam logic [CNT_W:0]   ONE_C     = (CNT_W+1)'(1);

   logic             sync_q1;
   logic             sync_q2;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W:0]   run_len;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q1 <= i_line;
         sync_q2 <= sync_q1;
         prev_q  <= sync_q2;
         if (o_edge) begin
            cnt_q <= '0;
         end else if (cnt_q != LONG_C) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Length of the run that the current edge terminates.
   assign run_len  = {1'b0, cnt_q} + ONE_C;

   assign o_sync   = sync_q2;
   assign o_edge   = sync_q2 ^ prev_q;
   assign o_short  = o_edge && (run_len >= SMIN_C) && (run_len <= SMAX_C);
   assign o_glitch = o_edge && (run_len < SMIN_C);
   assign o_over   = o_edge && (run_len > SMAX_C);
   // Fires once, on the cycle the counter steps onto saturation; an edge that cycle wins.
   assign o_long   = !o_edge && (cnt_q == LONG_M1_C);

endmodule

// File: rtl/lv_pwm_intb_decode.sv
// rtl/lv_pwm_intb_decode.sv - decodes HV interrupt frames, gate-wave level and watchdog loss from the PWM feedback line
module lv_pwm_intb_decode
   import lv_pwm_intb_decode_pkg::*;
#(
   parameter int EXT_CYC_NUM = PWM_INTB_EXT_CYC_NUM,
   parameter int EXT_TOL     = PWM_INTB_EXT_TOL,
   parameter int WDG_TO_MULT = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_pwm_intb_n,
   input  logic       i_wdgintb_en,
   input  logic [1:0] i_wdgintb_config,
   input  logic       i_wdg_clr,
   output logic       o_hv_intb_n,
   output logic       o_hv_gwave,
   output logic       o_frame_vld,
   output logic       o_frame_err,
   output logic       o_wdg_lost
);

   localparam int WDG_W = WDG_CNT_W + 2;

   logic line_sync;
   logic run_edge;
   logic run_short;
   logic run_glitch;
   logic run_over;
   logic run_long;
   logic run_bad;

   intb_state_e state_q;
   intb_state_e state_d;
   logic        intb_n_q;
   logic        intb_n_d;
   logic        vld_q;
   logic        vld_d;
   logic        err_q;
   logic        err_d;
   logic        gwave_q;

   logic [WDG_W-1:0] wdg_cnt_q;
   logic [WDG_W-1:0] wdg_thr;
   logic             wdg_set;
   logic             wdg_lost_q;

   lv_pwm_intb_decode_sync_run_meter #(
      .EXT_CYC_NUM (EXT_CYC_NUM),
      .EXT_TOL     (EXT_TOL)
   ) u_meter (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_line   (i_pwm_intb_n),
      .o_sync   (line_sync),
      .o_edge   (run_edge),
      .o_short  (run_short),
      .o_glitch (run_glitch),
      .o_over   (run_over),
      .o_long   (run_long)
   );

   // Any edge that does not close a short segment breaks the frame.
   assign run_bad = run_glitch | run_over;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         intb_n_q <= 1'b1;
         vld_q    <= 1'b0;
         err_q    <= 1'b0;
         gwave_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         intb_n_q <= intb_n_d;
         vld_q    <= vld_d;
         err_q    <= err_d;
         if (run_long) begin
            gwave_q <= line_sync;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      intb_n_d = intb_n_q;
      vld_d    = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run_edge) state_d = ST_RUN1;
         end
         ST_RUN1: begin
            if (run_short) begin
               state_d = ST_RUN2;
            end else if (run_bad) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (run_long) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN2: begin
            if (run_short) begin
               state_d = ST_RUN3;
            end else if (run_bad) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (run_long) begin
               state_d  = ST_IDLE;
               intb_n_d = 1'b0;
               vld_d    = 1'b1;
            end
         end
         ST_RUN3: begin
            if (run_short) begin
               state_d = ST_RUN4;
            end else if (run_bad || run_long) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_RUN4: begin
            if (run_edge) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (run_long) begin
               state_d  = ST_IDLE;
               intb_n_d = 1'b1;
               vld_d    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Threshold follows the live config, so a lowered threshold can trip at once.
   assign wdg_thr = WDG_W'(WDG_TO_MULT) * {2'b00, WDG_INTB_TH[i_wdgintb_config]};
   assign wdg_set = i_wdgintb_en && (wdg_cnt_q >= wdg_thr);

   always_ff @(posedge i_clk) begin
      if (i_rst || !i_wdgintb_en) begin
         wdg_cnt_q <= '0;
      end else if (vld_q) begin
         wdg_cnt_q <= '0;
      end else if (wdg_cnt_q != {WDG_W{1'b1}}) begin
         wdg_cnt_q <= wdg_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wdg_lost_q <= 1'b0;
      end else if (wdg_set) begin
         wdg_lost_q <= 1'b1;
      end else if (i_wdg_clr) begin
         wdg_lost_q <= 1'b0;
      end
   end

   assign o_hv_intb_n = intb_n_q;
   assign o_hv_gwave  = gwave_q;
   assign o_frame_vld = vld_q;
   assign o_frame_err = err_q;
   assign o_wdg_lost  = wdg_lost_q;

endmodule

// File: tb/tb_lv_pwm_intb_decode.sv
// tb/tb_lv_pwm_intb_decode.sv - self-checking bench for lv_pwm_intb_decode
module tb_lv_pwm_intb_decode;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_pwm_intb_n = 1'b0;
   logic       i_wdgintb_en = 1'b0;
   logic [1:0] i_wdgintb_config = 2'd0;
   logic       i_wdg_clr = 1'b0;
   logic       o_hv_intb_n;
   logic       o_hv_gwave;
   logic       o_frame_vld;
   logic       o_frame_err;
   logic       o_wdg_lost;

   int checks = 0;
   int failures = 0;
   int vld_seen = 0;
   int err_seen = 0;

   logic line_lv = 1'b0;
   logic exp_intb = 1'b1;

   // Short window 6..10, stable after 11 synced cycles, 2 sync stages + 1 output register.
   localparam int SMIN = 6;
   localparam int SMAX = 10;
   localparam int LAT = 2 + 11 + 1;
   localparam int WDG_TIMEOUT = 2 * 32;

   lv_pwm_intb_decode dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_pwm_intb_n     (i_pwm_intb_n),
      .i_wdgintb_en     (i_wdgintb_en),
      .i_wdgintb_config (i_wdgintb_config),
      .i_wdg_clr        (i_wdg_clr),
      .o_hv_intb_n      (o_hv_intb_n),
      .o_hv_gwave       (o_hv_gwave),
      .o_frame_vld      (o_frame_vld),
      .o_frame_err      (o_frame_err),
      .o_wdg_lost       (o_wdg_lost)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (o_frame_vld) vld_seen++;
      if (o_frame_err) err_seen++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic lv, input int n);
      i_pwm_intb_n = lv;
      line_lv = lv;
      tick(n);
   endtask

   // kind: 0 intb0 frame, 1 intb1 frame, 2 glitch, 3 two-segment frame, 4 plain PWM edge
   task automatic rand_step(input int kind);
      int   v0, e0, gap, ev, ee;
      logic base;
      v0 = vld_seen;
      e0 = err_seen;
      base = line_lv;
      gap = $urandom_range(25, 45);
      ev = 0;
      ee = 0;
      case (kind)
         0: begin
            hold(!base, $urandom_range(SMIN, SMAX));
            chk("rnd_gwave_in_frame0", o_hv_gwave, base);
            hold(base, gap);
            ev = 1;
            exp_intb = 1'b0;
         end
         1: begin
            hold(!base, $urandom_range(SMIN, SMAX));
            hold(base, $urandom_range(SMIN, SMAX));
            hold(!base, $urandom_range(SMIN, SMAX));
            chk("rnd_gwave_in_frame1", o_hv_gwave, base);
            hold(base, gap);
            ev = 1;
            exp_intb = 1'b1;
         end
         2: begin
            hold(!base, $urandom_range(1, SMIN - 1));
            hold(base, gap);
            ee = 1;
         end
         3: begin
            hold(!base, $urandom_range(SMIN, SMAX));
            hold(base, $urandom_range(SMIN, SMAX));
            hold(!base, gap);
            ee = 1;
         end
         default: begin
            hold(!base, $urandom_range(25, 60));
         end
      endcase
      chk("rnd_vld_count", vld_seen - v0, ev);
      chk("rnd_err_count", err_seen - e0, ee);
      chk("rnd_intb_n", o_hv_intb_n, exp_intb);
      chk("rnd_gwave", o_hv_gwave, line_lv);
   endtask

   initial begin
      int v0, e0;

      // Reset values
      tick(3);
      chk("rst_intb_n", o_hv_intb_n, 1);
      chk("rst_gwave", o_hv_gwave, 0);
      chk("rst_vld", o_frame_vld, 0);
      chk("rst_err", o_frame_err, 0);
      chk("rst_lost", o_wdg_lost, 0);
      i_rst = 1'b0;

      // intb1 frame from low: intb_n stays 1, one vld, gwave stays 0
      hold(1'b0, 100);
      v0 = vld_seen;
      hold(1'b1, 8);
      hold(1'b0, 8);
      hold(1'b1, 8);
      chk("intb1_gwave_mid", o_hv_gwave, 0);
      hold(1'b0, 30);
      chk("intb1_vld", vld_seen - v0, 1);
      chk("intb1_intb_n", o_hv_intb_n, 1);
      chk("intb1_gwave", o_hv_gwave, 0);

      // intb0 frame with exact decode latency from the final pin edge
      v0 = vld_seen;
      hold(1'b1, 7);
      hold(1'b0, LAT - 1);
      chk("intb0_vld_early", o_frame_vld, 0);
      chk("intb0_intb_early", o_hv_intb_n, 1);
      tick(1);
      chk("intb0_vld_on_time", o_frame_vld, 1);
      chk("intb0_intb_on_time", o_hv_intb_n, 0);
      tick(1);
      chk("intb0_vld_one_cycle", o_frame_vld, 0);
      tick(20);
      chk("intb0_vld_count", vld_seen - v0, 1);
      chk("intb0_gwave", o_hv_gwave, 0);

      // intb1 again: 0 -> 1 transition
      hold(1'b1, 8);
      hold(1'b0, 8);
      hold(1'b1, 8);
      hold(1'b0, 30);
      chk("intb1b_intb_n", o_hv_intb_n, 1);

      // Glitch: err, intb unchanged
      e0 = err_seen;
      v0 = vld_seen;
      hold(1'b1, 4);
      hold(1'b0, 30);
      chk("glitch_err", err_seen - e0, 1);
      chk("glitch_vld", vld_seen - v0, 0);
      chk("glitch_intb_n", o_hv_intb_n, 1);

      // Two-segment frame: err
      e0 = err_seen;
      hold(1'b1, 8);
      hold(1'b0, 8);
      hold(1'b1, 30);
      chk("twoseg_err", err_seen - e0, 1);
      chk("twoseg_intb_n", o_hv_intb_n, 1);
      hold(1'b0, 30);

      // Plain PWM: gwave follows with fixed latency, no pulses
      e0 = err_seen;
      v0 = vld_seen;
      hold(1'b1, LAT - 1);
      chk("pwm_rise_early", o_hv_gwave, 0);
      tick(1);
      chk("pwm_rise_on_time", o_hv_gwave, 1);
      tick(50 - LAT);
      hold(1'b0, LAT - 1);
      chk("pwm_fall_early", o_hv_gwave, 1);
      tick(1);
      chk("pwm_fall_on_time", o_hv_gwave, 0);
      tick(50 - LAT);
      chk("pwm_no_err", err_seen - e0, 0);
      chk("pwm_no_vld", vld_seen - v0, 0);

      // Randomized frames and PWM edges
      for (int i = 0; i < 24; i++) begin
         rand_step(int'($urandom_range(0, 4)));
      end
      if (line_lv) hold(1'b0, 30);

      // Watchdog timeout, clear collides with continuing timeout
      i_wdgintb_en = 1'b1;
      i_wdgintb_config = 2'd0;
      tick(WDG_TIMEOUT - 4);
      chk("wdg_not_yet", o_wdg_lost, 0);
      tick(10);
      chk("wdg_lost", o_wdg_lost, 1);
      i_wdg_clr = 1'b1;
      tick(1);
      chk("wdg_set_wins", o_wdg_lost, 1);
      i_wdgintb_en = 1'b0;
      tick(1);
      chk("wdg_cleared", o_wdg_lost, 0);
      i_wdg_clr = 1'b0;

      // A decoded frame restarts the watchdog count
      i_wdgintb_en = 1'b1;
      tick(40);
      hold(1'b1, 7);
      hold(1'b0, 30);
      tick(30);
      chk("wdg_frame_restarts", o_wdg_lost, 0);
      tick(40);
      chk("wdg_lost_again", o_wdg_lost, 1);
      i_wdgintb_en = 1'b0;
      i_wdg_clr = 1'b1;
      tick(1);
      i_wdg_clr = 1'b0;
      exp_intb = 1'b0;
      chk("wdg_intb_n", o_hv_intb_n, exp_intb);

      // Reset during RUN3 with gwave high and intb low
      hold(1'b1, 30);
      chk("pre_rst_gwave", o_hv_gwave, 1);
      hold(1'b0, 8);
      hold(1'b1, 8);
      e0 = err_seen;
      hold(1'b0, 4);
      i_rst = 1'b1;
      tick(1);
      i_rst = 1'b0;
      chk("midrst_intb_n", o_hv_intb_n, 1);
      chk("midrst_gwave", o_hv_gwave, 0);
      chk("midrst_vld", o_frame_vld, 0);
      chk("midrst_err", o_frame_err, 0);
      chk("midrst_lost", o_wdg_lost, 0);
      hold(1'b0, 40);
      chk("midrst_no_err", err_seen - e0, 0);
      v0 = vld_seen;
      hold(1'b1, 7);
      hold(1'b0, 30);
      chk("post_rst_vld", vld_seen - v0, 1);
      chk("post_rst_intb_n", o_hv_intb_n, 0);
      chk("post_rst_no_err", err_seen - e0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
